// File: rtl/chip_sched_pkg.sv
// chip_sched_pkg: shared state encoding and default sizing for the chip test scheduler.
package chip_sched_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DISPLAY} sched_state_t;
  localparam int N_CHIPS_DEF = 8;
  localparam int SETTLE_DEF  = 16;
  localparam int TIMEOUT_DEF = 1000000;
endpackage

// File: rtl/sched_timer.sv
// sched_timer: loadable down-counter with zero flag, shared by the settle and run phases.
module sched_timer #(
  parameter int W = 20
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  assign o_cnt  = r_cnt;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/chip_test_scheduler.sv
// chip_test_scheduler: runs one 74xx tester at a time on the shared socket and latches its verdict.
module chip_test_scheduler
  import chip_sched_pkg::*;
#(
  parameter int N_CHIPS     = N_CHIPS_DEF,
  parameter int SEL_W       = 3,
  parameter int SETTLE_CYC  = SETTLE_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [SEL_W-1:0]   Chip_Sel,
  input  logic [N_CHIPS-1:0] Chip_Done,
  input  logic [N_CHIPS-1:0] Chip_RSLT,
  output logic [N_CHIPS-1:0] Chip_Run,
  output logic [N_CHIPS-1:0] Disp_Rslt,
  output logic [SEL_W-1:0]   Mux_Sel,
  output logic               Busy,
  output logic               Done,
  output logic               RSLT,
  output logic               Timeout,
  output logic               Sel_Err
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  sched_state_t       r_state;
  logic               r_start_q, r_busy, r_done, r_rslt, r_timeout, r_sel_err;
  logic [SEL_W-1:0]   r_sel;
  logic [N_CHIPS-1:0] r_run, r_disp, w_onehot;
  logic [CW-1:0]      w_cnt, w_load_val;
  logic               w_zero, w_edge, w_accept, w_sel_ok, w_done, w_load;
  assign w_edge     = Start & ~r_start_q;
  assign w_accept   = w_edge & (r_state == IDLE || r_state == DISPLAY);
  assign w_sel_ok   = {1'b0, Chip_Sel} < (SEL_W+1)'(N_CHIPS);
  assign w_onehot   = N_CHIPS'(1) << r_sel;
  // the first RUN cycle is the only one with the full timeout still loaded, so a stale Done is masked there
  assign w_done     = Chip_Done[r_sel] & (w_cnt != CW'(TIMEOUT_CYC - 1));
  assign w_load     = (w_accept & w_sel_ok) | (r_state == SETTLE & w_zero);
  assign w_load_val = r_state == SETTLE ? CW'(TIMEOUT_CYC - 1) : CW'(SETTLE_CYC - 1);
  sched_timer #(.W(CW)) u_timer (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_load(w_load),
    .i_val (w_load_val),
    .i_en  (r_state == SETTLE || r_state == RUN),
    .o_cnt (w_cnt),
    .o_zero(w_zero)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_sel     <= '0;
      r_run     <= '0;
      r_disp    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rslt    <= 1'b0;
      r_timeout <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_start_q <= Start;
      if (w_accept) begin
        r_state   <= w_sel_ok ? SETTLE : DISPLAY;
        r_sel     <= Chip_Sel;
        r_run     <= '0;
        r_disp    <= '0;
        r_busy    <= w_sel_ok;
        r_done    <= ~w_sel_ok;
        r_rslt    <= 1'b0;
        r_timeout <= 1'b0;
        r_sel_err <= ~w_sel_ok;
      end else if (r_state == SETTLE && w_zero) begin
        r_state <= RUN;
        r_run   <= w_onehot;
      end else if (r_state == RUN && (w_done || w_zero)) begin
        r_state   <= DISPLAY;
        r_run     <= '0;
        r_disp    <= w_onehot;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_rslt    <= w_done & Chip_RSLT[r_sel];
        r_timeout <= ~w_done;
      end
    end
  assign Chip_Run  = r_run;
  assign Disp_Rslt = r_disp;
  assign Mux_Sel   = r_sel;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign RSLT      = r_rslt;
  assign Timeout   = r_timeout;
  assign Sel_Err   = r_sel_err;
endmodule

// File: tb/tb_chip_test_scheduler.sv
// tb_chip_test_scheduler: table-driven scoreboard bench for the chip test scheduler (6 testers, short timeout).
module tb_chip_test_scheduler;
  localparam int N   = 6;
  localparam int SET = 4;
  localparam int TO  = 100;
  typedef struct {
    logic [2:0]   sel;
    int           done_cyc;
    logic         stale;
    logic         rslt_in;
    logic         e_rslt;
    logic         e_to;
    logic         e_serr;
    logic [N-1:0] e_disp;
    int           e_runs;
    int           e_lat;
  } vec_t;
  logic         Clk = 0, Reset = 1, Start = 0;
  logic [2:0]   Chip_Sel = '0, Mux_Sel;
  logic [N-1:0] Chip_Done = '0, Chip_RSLT = '0, Chip_Run, Disp_Rslt;
  logic         Busy, Done, RSLT, Timeout, Sel_Err;
  int total = 0, bad = 0;
  vec_t vecs[$];
  vec_t sb[$];
  chip_test_scheduler #(.N_CHIPS(N), .SEL_W(3), .SETTLE_CYC(SET), .TIMEOUT_CYC(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Chip_Sel(Chip_Sel),
    .Chip_Done(Chip_Done), .Chip_RSLT(Chip_RSLT), .Chip_Run(Chip_Run),
    .Disp_Rslt(Disp_Rslt), .Mux_Sel(Mux_Sel), .Busy(Busy), .Done(Done),
    .RSLT(RSLT), .Timeout(Timeout), .Sel_Err(Sel_Err)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_run"}, 32'(Chip_Run), 0);
    chk({nm, "_disp"}, 32'(Disp_Rslt), 0);
    chk({nm, "_flags"}, {27'd0, Busy, Done, RSLT, Timeout, Sel_Err}, 0);
    chk({nm, "_mux"}, 32'(Mux_Sel), 0);
  endtask
  task automatic pulse_start(input logic [2:0] sel);
    @(negedge Clk);
    Chip_Sel = sel;
    Start = 1;
    @(negedge Clk);
    Start = 0;
  endtask
  task automatic wait_run(output int k);
    k = 1;
    while (Chip_Run == '0 && k < 50) begin
      @(negedge Clk);
      k++;
    end
    chk("wait_run_bound", 32'(Chip_Run != '0), 1);
  endtask
  task automatic do_test(input vec_t v);
    int k, runs;
    logic shape_ok;
    logic [N-1:0] oh;
    vec_t e;
    oh = N'(1) << v.sel;
    sb.push_back(v);
    @(negedge Clk);
    Chip_Done = '0;
    Chip_RSLT = '0;
    if (v.stale) begin
      Chip_Done[v.sel] = 1;
      Chip_RSLT[v.sel] = v.rslt_in;
    end
    pulse_start(v.sel);
    k = 1;
    runs = 0;
    shape_ok = 1;
    chk("busy_after_edge", 32'(Busy), 32'(!v.e_serr));
    while (!Done && k < 400) begin
      if (Chip_Run != '0) begin
        runs++;
        if (Chip_Run != oh || Disp_Rslt != '0) shape_ok = 0;
        if (v.done_cyc > 0 && runs >= v.done_cyc) begin
          Chip_Done[v.sel] = 1;
          Chip_RSLT[v.sel] = v.rslt_in;
        end
      end
      @(negedge Clk);
      k++;
    end
    e = sb.pop_front();
    chk("done_reached", 32'(Done), 1);
    chk("latency", k, e.e_lat);
    chk("run_cycles", runs, e.e_runs);
    chk("run_onehot", 32'(shape_ok), 1);
    chk("rslt", 32'(RSLT), 32'(e.e_rslt));
    chk("timeout", 32'(Timeout), 32'(e.e_to));
    chk("sel_err", 32'(Sel_Err), 32'(e.e_serr));
    chk("disp_rslt", 32'(Disp_Rslt), 32'(e.e_disp));
    chk("mux_sel", 32'(Mux_Sel), 32'(e.sel));
    chk("run_off_busy_off", {30'd0, Chip_Run != '0, Busy}, 0);
  endtask
  initial begin
    int k;
    vecs.push_back('{3'd3, 5,   0, 1, 1, 0, 0, 6'h08, 5,   SET + 6});
    vecs.push_back('{3'd5, 0,   0, 0, 0, 1, 0, 6'h20, TO,  SET + TO + 1});
    vecs.push_back('{3'd6, 0,   0, 0, 0, 0, 1, 6'h00, 0,   1});
    vecs.push_back('{3'd2, 0,   1, 1, 1, 0, 0, 6'h04, 2,   SET + 3});
    vecs.push_back('{3'd0, TO,  0, 1, 1, 0, 0, 6'h01, TO,  SET + TO + 1});
    vecs.push_back('{3'd4, TO+1,0, 1, 0, 1, 0, 6'h10, TO,  SET + TO + 1});
    vecs.push_back('{3'd1, 3,   0, 0, 0, 0, 0, 6'h02, 3,   SET + 4});
    vecs.push_back('{3'd7, 0,   0, 0, 0, 0, 1, 6'h00, 0,   1});
    vecs.push_back('{3'd2, 1,   0, 1, 1, 0, 0, 6'h04, 2,   SET + 3});
    repeat (2) @(negedge Clk);
    chk_idle_outputs("reset");
    Reset = 0;
    @(negedge Clk);
    chk_idle_outputs("idle");
    foreach (vecs[i]) do_test(vecs[i]);
    // edges, selection changes and a foreign Done during RUN are all ignored
    Chip_Done = '0;
    Chip_RSLT = '0;
    pulse_start(3'd1);
    wait_run(k);
    @(negedge Clk);
    Chip_Sel = 3'd4;
    Chip_Done[4] = 1;
    Chip_RSLT[4] = 1;
    Start = 1;
    @(negedge Clk);
    Start = 0;
    repeat (3) @(negedge Clk);
    chk("run_ignore_mux", 32'(Mux_Sel), 1);
    chk("run_ignore_run", 32'(Chip_Run), 32'h02);
    chk("run_ignore_state", {30'd0, Busy, Done}, 32'b10);
    Chip_Done[1] = 1;
    Chip_RSLT[1] = 1;
    k = 0;
    while (!Done && k < 20) begin
      @(negedge Clk);
      k++;
    end
    chk("run_ignore_done", {29'd0, Done, RSLT, Timeout}, 32'b110);
    chk("run_ignore_disp", 32'(Disp_Rslt), 32'h02);
    Chip_Sel = 3'd3;
    repeat (2) @(negedge Clk);
    chk("display_hold_mux", 32'(Mux_Sel), 1);
    chk("display_hold_done", {30'd0, Done, RSLT}, 32'b11);
    // reset in the third RUN cycle clears everything at once
    Chip_Done = '0;
    pulse_start(3'd3);
    wait_run(k);
    repeat (2) @(negedge Clk);
    chk("pre_reset_run", 32'(Chip_Run), 32'h08);
    Reset = 1;
    #1;
    chk_idle_outputs("midrun_reset");
    @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    chk_idle_outputs("post_reset");
    do_test(vecs[0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
